// File: rtl/unpool_concat_pkg.sv
// Shared fixed-point, sizing and latency helpers used by the unpool/concat
// stage and its neighbouring pooling and integration stages.
package unpool_concat_pkg;

  localparam int unsigned DEF_INT_BITW  = 5;
  localparam int unsigned DEF_FRAC_BITW = 8;
  localparam int unsigned DEF_UNITS     = 12;

  // Ceiling log2, never below 1 so a counter always has at least one bit.
  function automatic int unsigned log2(input int unsigned n);
    int unsigned r;
    r = 1;
    while ((32'd1 << r) < n) r++;
    return r;
  endfunction

  function automatic int unsigned fixed_bitw(input int unsigned int_bitw,
                                             input int unsigned frac_bitw);
    return int_bitw + frac_bitw;
  endfunction

  // Two full window rows plus the registered line-buffer read.
  function automatic int unsigned latency(input int unsigned w_width);
    return 2 * w_width + 2;
  endfunction

  localparam int unsigned DEF_FIXED_BITW = fixed_bitw(DEF_INT_BITW, DEF_FRAC_BITW);

endpackage

// File: rtl/unpool_concat_if.sv
// Raster stream bundle for the unpool/concat stage: pooled + skip features in,
// concatenated full-resolution vector out, with coordinates riding alongside.
interface unpool_concat_if #(
  parameter int unsigned DW = 156,
  parameter int unsigned VB = 3,
  parameter int unsigned HB = 3
);

  logic              in_enable;
  logic [DW-1:0]     in_pool;
  logic [DW-1:0]     in_skip;
  logic [VB-1:0]     in_vcnt;
  logic [HB-1:0]     in_hcnt;
  logic              out_enable;
  logic [2*DW-1:0]   out_y;
  logic [VB-1:0]     out_vcnt;
  logic [HB-1:0]     out_hcnt;

  modport master (
    output in_enable, in_pool, in_skip, in_vcnt, in_hcnt,
    input  out_enable, out_y, out_vcnt, out_hcnt
  );

  modport slave (
    input  in_enable, in_pool, in_skip, in_vcnt, in_hcnt,
    output out_enable, out_y, out_vcnt, out_hcnt
  );

endinterface

// File: rtl/unpool_bank_ram.sv
// Ping-pong half-width line buffer: two banks, one write port, one registered
// read port. Contents are deliberately not reset.
module unpool_bank_ram #(
  parameter int unsigned DW    = 156,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic          wbank_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          rbank_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2][DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[wbank_i][waddr_i] <= wdata_i;
    rdata_o <= mem_q[rbank_i][raddr_i];
  end

endmodule

// File: rtl/unpool_concat.sv
// Nearest-neighbour 2x upsampling of the pooled stream via ping-pong line
// buffers, concatenated with the latency-matched full-resolution skip stream.
module unpool_concat
  import unpool_concat_pkg::*;
#(
  parameter int unsigned HEIGHT    = 4,
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned W_HEIGHT  = 6,
  parameter int unsigned W_WIDTH   = 8,
  parameter int unsigned UNITS     = DEF_UNITS,
  parameter int unsigned INT_BITW  = DEF_INT_BITW,
  parameter int unsigned FRAC_BITW = DEF_FRAC_BITW
) (
  input  logic            clock,
  input  logic            n_rst,
  unpool_concat_if.slave  bus
);

  localparam int unsigned FIXED_BITW = fixed_bitw(INT_BITW, FRAC_BITW);
  localparam int unsigned DW         = FIXED_BITW * UNITS;
  localparam int unsigned VB         = log2(W_HEIGHT);
  localparam int unsigned HB         = log2(W_WIDTH);
  localparam int unsigned AW         = HB - 1;
  localparam int unsigned DEPTH      = W_WIDTH / 2;
  localparam int unsigned LATENCY    = latency(W_WIDTH);

  localparam logic [VB:0] HEIGHT_C = (VB + 1)'(HEIGHT);
  localparam logic [HB:0] WIDTH_C  = (HB + 1)'(WIDTH);

  if (HEIGHT % 2 != 0) begin : g_bad_height
    $error("unpool_concat: HEIGHT must be even");
  end
  if (WIDTH % 2 != 0) begin : g_bad_width
    $error("unpool_concat: WIDTH must be even");
  end
  if (W_WIDTH % 2 != 0 || W_WIDTH <= 2) begin : g_bad_w_width
    $error("unpool_concat: W_WIDTH must be even and greater than 2");
  end
  if (W_HEIGHT <= HEIGHT) begin : g_bad_w_height
    $error("unpool_concat: W_HEIGHT must exceed HEIGHT");
  end

  typedef struct packed {
    logic          en;
    logic [VB-1:0] vcnt;
    logic [HB-1:0] hcnt;
    logic [DW-1:0] skip;
  } stage_t;

  stage_t        pipe_d;
  stage_t        pipe_q [LATENCY];
  logic          in_act;
  logic          out_act;
  logic          we;
  logic [DW-1:0] ram_q;

  always_comb begin
    pipe_d      = '0;
    pipe_d.en   = bus.in_enable;
    pipe_d.vcnt = bus.in_vcnt;
    pipe_d.hcnt = bus.in_hcnt;
    pipe_d.skip = bus.in_skip;
    in_act = ({1'b0, bus.in_vcnt} < HEIGHT_C) && ({1'b0, bus.in_hcnt} < WIDTH_C);
    // Only the bottom-right pixel of each 2x2 block carries the pooled value.
    we = n_rst && bus.in_enable && bus.in_vcnt[0] && bus.in_hcnt[0] && in_act;
  end

  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      for (int unsigned i = 0; i < LATENCY; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= pipe_d;
      for (int unsigned i = 1; i < LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  // Read address comes from the stage one cycle ahead of the output so the
  // registered RAM read lands exactly on the output stage.
  unpool_bank_ram #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk_i   (clock),
    .we_i    (we),
    .wbank_i (bus.in_vcnt[1]),
    .waddr_i (bus.in_hcnt[HB-1:1]),
    .wdata_i (bus.in_pool),
    .rbank_i (pipe_q[LATENCY-2].vcnt[1]),
    .raddr_i (pipe_q[LATENCY-2].hcnt[HB-1:1]),
    .rdata_o (ram_q)
  );

  always_comb begin
    out_act = pipe_q[LATENCY-1].en
           && ({1'b0, pipe_q[LATENCY-1].vcnt} < HEIGHT_C)
           && ({1'b0, pipe_q[LATENCY-1].hcnt} < WIDTH_C);
    bus.out_enable = pipe_q[LATENCY-1].en;
    bus.out_vcnt   = pipe_q[LATENCY-1].vcnt;
    bus.out_hcnt   = pipe_q[LATENCY-1].hcnt;
    bus.out_y      = '0;
    if (out_act) bus.out_y = {ram_q, pipe_q[LATENCY-1].skip};
  end

endmodule

// File: doc/unpool_concat.md
Name: unpool_concat

Overview:
- Stage directly upstream of the 3-layer integration network.
- Upsamples a 2x2-pooled feature stream back to full resolution by nearest-neighbour replication, using ping-pong half-width line buffers.
- Concatenates the upsampled features with a latency-matched full-resolution skip stream. The result is the 2n-unit input vector the integration network expects.
- Operates on the codebase's continuous raster stream: one pixel per clock, with vcnt/hcnt spanning the window (W_HEIGHT x W_WIDTH, including blanking).

Parameters:
- HEIGHT, -1, active image height; must be even.
- WIDTH, -1, active image width; must be even.
- W_HEIGHT, -1, window height including blanking; must be > HEIGHT.
- W_WIDTH, -1, window width including blanking; must be even and > 2.
- UNITS, 12, feature units per stream.
- INT_BITW, 5, integer bits of the fixed-point format.
- FRAC_BITW, 8, fractional bits; FIXED_BITW = INT_BITW + FRAC_BITW.

Ports:
- clock  in  1  system clock.
- n_rst  in  1  asynchronous active-low reset.
- in_enable  in  1  input cycle carries valid frame data.
- in_pool  in  FIXED_BITW*UNITS  pooled features; meaningful only where in_vcnt[0]=1 and in_hcnt[0]=1, inside the active area. Unit 0 at MSB end ([0:...] ordering).
- in_skip  in  FIXED_BITW*UNITS  full-resolution skip features for the current pixel.
- in_vcnt  in  log2(W_HEIGHT)  input row.
- in_hcnt  in  log2(W_WIDTH)  input column.
- out_enable  out  1  in_enable delayed by LATENCY.
- out_y  out  FIXED_BITW*UNITS*2  {unpooled[0:UNITS-1], skip[0:UNITS-1]}.
- out_vcnt  out  log2(W_HEIGHT)  in_vcnt delayed by LATENCY.
- out_hcnt  out  log2(W_WIDTH)  in_hcnt delayed by LATENCY.

Behaviour:
- Reset: all outputs and all delay-pipeline registers clear to 0 asynchronously; line-buffer contents are not reset.
- Latency: LATENCY = 2*W_WIDTH + 2 clocks, fixed, identical for data, enable and coordinates.
- Write:
  - Condition: in_enable=1, in_vcnt[0]=1, in_hcnt[0]=1, in_vcnt<HEIGHT, in_hcnt<WIDTH.
  - Data: in_pool is written to bank in_vcnt[1], address in_hcnt>>1.
  - No write on any other cycle.
- Read (unpooled half of out_y):
  - At output coordinate (v,h) inside the active area, the value equals the pooled vector written for block (v>>1, h>>1), i.e. bank v[1], address h>>1.
  - Ping-pong banking is mandatory: block row b+1 is written up to 2 clocks before the last read of block row b's same entry.
- Skip half of out_y: in_skip delayed exactly LATENCY clocks.
- Blanking / disabled cycles: out_y = 0 whenever out_enable=0, out_vcnt>=HEIGHT or out_hcnt>=WIDTH. Coordinates still propagate.
- Frame wrap: no counter of its own; behaviour follows the coordinates. W_HEIGHT > HEIGHT guarantees that the first write of the next frame follows the last read of the previous frame.
- Reset mid-frame:
  - Outputs are 0 and out_enable=0 for LATENCY cycles after release.
  - Buffer contents are stale but unobservable until rewritten, because reads follow writes by the latency.
- Line-buffer RAM read is registered (1 cycle). The read address is derived from coordinates 1 cycle before the output stage, so the total latency remains LATENCY.
- Elaboration error if WIDTH, HEIGHT or W_WIDTH is odd, or if W_HEIGHT <= HEIGHT.

Decomposition:
- Shared package/include: FIXED_BITW derivation, the log2 function, the LATENCY expression. The integration network and the pooling stage reuse these.
- One sub-module: unpool_bank_ram.
  - 2 banks x (W_WIDTH/2) words x FIXED_BITW*UNITS bits.
  - Single write port (bank, addr, data, we); single registered read port (bank, addr).
  - Inferable as block RAM.
- The skip/enable/coordinate delay is a plain shift register of depth LATENCY inside the top module.

Test Plan:
- Single block, with WIDTH=4, HEIGHT=4, W_WIDTH=8, W_HEIGHT=6 (LATENCY=18): in_pool unit0=13'h0A5 at input (1,1), all else 0 -> out_y unit0=13'h0A5 at out coords (0,0),(0,1),(1,0),(1,1), first appearing 18 clocks after input (0,0); unit0=0 at (0,2),(2,0).
- Full frame: pooled value 16*bv+bh+1 per block -> every active output pixel (v,h) carries 16*(v>>1)+(h>>1)+1 in all unpooled units; no value from block row b+1 appears in rows 2b..2b+1.
- Skip alignment: in_skip unit11 = row*8+col for each pixel -> out_y skip unit11 equals out_vcnt*8+out_hcnt on every active cycle.
- Blanking: drive in_pool=all-ones on blanking coordinates (h=5, v=5) -> out_y=0 at every output coordinate with out_hcnt>=4 or out_vcnt>=4; buffer contents are not corrupted (next frame matches expected).
- Back-to-back frames with different patterns -> frame 2 output rows 0-1 show frame 2 block row 0, never frame 1 data.
- Reset asserted mid-frame at input (2,3), released 3 clocks later -> outputs 0 immediately; out_enable stays 0 for exactly 18 clocks after release; the following full frame is correct.
